// File: rtl/spi_bit_sequencer.sv
// SPI mode-0 single-byte transmit sequencer driving an external 8:1 bit-select mux.
// Define SPI_SEQ_MISO_CAPTURE_EN to build the MISO receive-capture path.
module spi_bit_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] tx_word,
  output logic [2:0] sel,
  input  logic       mux_bit,
  input  logic       miso,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TRAIL = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    rise_cnt_q, rise_cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    tx_word_q, tx_word_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          div_wrap;
  logic          accept;

  assign div_wrap = (div_q == DIV_LAST);
  // The last GAP cycle doubles as the first IDLE cycle so a held start runs back-to-back.
  assign accept   = start & ((state_q == IDLE) | ((state_q == GAP) & div_wrap));

  // Next-state and output computation.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    rise_cnt_d = rise_cnt_q;
    sel_d      = sel_q;
    tx_word_d  = tx_word_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (accept) begin
      state_d    = SHIFT;
      tx_word_d  = tx_data;
      cs_n_d     = 1'b0;
      busy_d     = 1'b1;
      sel_d      = 3'd7;
      div_d      = '0;
      rise_cnt_d = 4'd0;
      sclk_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cs_n_d = 1'b1;
          busy_d = 1'b0;
          sclk_d = 1'b0;
        end
        SHIFT: begin
          mosi_d = mux_bit;
          if (div_wrap) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              rise_cnt_d = rise_cnt_q + 4'd1;
            end else if (rise_cnt_q == 4'd8) begin
              sel_d   = 3'd7;
              state_d = TRAIL;
            end else begin
              sel_d = sel_q - 3'd1;
            end
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        TRAIL: begin
          if (div_wrap) begin
            div_d   = '0;
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
            state_d = GAP;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        GAP: begin
          if (div_wrap) begin
            div_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          sclk_d  = 1'b0;
          sel_d   = 3'd7;
          div_d   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      rise_cnt_q <= 4'd0;
      sel_q      <= 3'd7;
      tx_word_q  <= 8'h00;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      rise_cnt_q <= rise_cnt_d;
      sel_q      <= sel_d;
      tx_word_q  <= tx_word_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_word = tx_word_q;
  assign sel     = sel_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef SPI_SEQ_MISO_CAPTURE_EN
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;

  // MISO is sampled on the edge that raises SCLK and published with done.
  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    if (accept) begin
      rx_shift_d = 8'h00;
    end else if ((state_q == SHIFT) && div_wrap && !sclk_q) begin
      rx_shift_d = {rx_shift_q[6:0], miso};
    end else begin
      rx_shift_d = rx_shift_q;
    end
    if (done_d) begin
      rx_data_d = rx_shift_q;
    end else begin
      rx_data_d = rx_data_q;
    end
  end

  // Receive capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx_data = rx_data_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_data     = 8'h00;
`endif

endmodule

// File: tb/tb_spi_bit_sequencer.sv
// Self-checking bench: DUT 0 at CLK_DIV=4, DUT 1 at CLK_DIV=2, checked against a timing-formula model.
module tb_spi_bit_sequencer;

  localparam int DA = 4;
  localparam int DB = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      start_i = 2'b00;
  logic [1:0][7:0] tx_data_i = '0;
  logic [1:0][7:0] tx_word_o;
  logic [1:0][2:0] sel_o;
  logic [1:0]      mux_bit_i;
  logic [1:0]      miso_i;
  logic [1:0]      sclk_o, cs_n_o, mosi_o, busy_o, done_o;
  logic [1:0][7:0] rx_data_o;

  logic [7:0] slave_byte = 8'h5A;
  logic [2:0] slave_idx = 3'd7;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit         m_act[2];
  int         m_t[2];
  logic [7:0] m_tx[2];
  logic [7:0] m_rx[2];

  logic [7:0] bits[2];
  int         done_cnt[2];

  always #5 clk = ~clk;

  spi_bit_sequencer #(.CLK_DIV(DA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .tx_data(tx_data_i[0]),
    .tx_word(tx_word_o[0]), .sel(sel_o[0]), .mux_bit(mux_bit_i[0]), .miso(miso_i[0]),
    .sclk(sclk_o[0]), .cs_n(cs_n_o[0]), .mosi(mosi_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .rx_data(rx_data_o[0])
  );

  spi_bit_sequencer #(.CLK_DIV(DB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .tx_data(tx_data_i[1]),
    .tx_word(tx_word_o[1]), .sel(sel_o[1]), .mux_bit(mux_bit_i[1]), .miso(miso_i[1]),
    .sclk(sclk_o[1]), .cs_n(cs_n_o[1]), .mosi(mosi_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .rx_data(rx_data_o[1])
  );

  // External 8:1 mux and a mode-0 slave that changes MISO on SCLK falls.
  assign mux_bit_i[0] = tx_word_o[0][sel_o[0]];
  assign mux_bit_i[1] = tx_word_o[1][sel_o[1]];
  assign miso_i[0]    = 1'b1;
  assign miso_i[1]    = slave_byte[slave_idx];

  initial forever begin
    @(negedge sclk_o[1] or posedge cs_n_o[1]);
    if (cs_n_o[1] === 1'b1) slave_idx = 3'd7;
    else slave_idx = slave_idx - 3'd1;
  end

  function automatic int dv(input int i);
    return (i == 0) ? DA : DB;
  endfunction

  function automatic logic [7:0] rx_expect(input int i);
`ifdef SPI_SEQ_MISO_CAPTURE_EN
    return (i == 0) ? 8'hFF : slave_byte;
`else
    return 8'h00;
`endif
  endfunction

  // Reference: t counts clk edges since the accepting edge; outputs follow from the timing rules.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_tx[i] = 8'h00; m_rx[i] = 8'h00;
      end else begin
        if (m_act[i]) begin
          m_t[i] = m_t[i] + 1;
          if (m_t[i] == 17 * dv(i)) m_rx[i] = rx_expect(i);
          if (m_t[i] == 18 * dv(i)) m_act[i] = 1'b0;
        end
        if (!m_act[i] && start_i[i]) begin
          m_act[i] = 1'b1; m_t[i] = 0; m_tx[i] = tx_data_i[i];
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input int i, input logic [7:0] got, input logic [7:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, i, cyc, got, want);
    end
  endtask

  task automatic compare_dut(input int i);
    int d, t, s;
    logic e_cs, e_busy, e_done, e_sclk, e_mosi;
    logic [2:0] e_sel;
    d = dv(i); t = m_t[i];
    e_cs = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0; e_sel = 3'd7;
    if (m_act[i]) begin
      e_busy = 1'b1;
      e_cs   = (t >= 17 * d);
      e_done = (t == 17 * d);
      e_sclk = (t < 16 * d) && (((t / d) % 2) == 1);
      if (t < 16 * d) e_sel = 3'(7 - t / (2 * d));
      if (t >= 1 && t <= 16 * d) begin
        s = 7 - (t - 1) / (2 * d);
        e_mosi = m_tx[i][s];
      end
    end
    chk("cs_n", i, {7'd0, cs_n_o[i]}, {7'd0, e_cs});
    chk("busy", i, {7'd0, busy_o[i]}, {7'd0, e_busy});
    chk("done", i, {7'd0, done_o[i]}, {7'd0, e_done});
    chk("sclk", i, {7'd0, sclk_o[i]}, {7'd0, e_sclk});
    chk("mosi", i, {7'd0, mosi_o[i]}, {7'd0, e_mosi});
    chk("sel", i, {5'd0, sel_o[i]}, {5'd0, e_sel});
    chk("tx_word", i, tx_word_o[i], m_tx[i]);
    chk("rx_data", i, rx_data_o[i], m_rx[i]);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic launch(input int i, input logic [7:0] b, output int t0);
    start_i[i] = 1'b1;
    tx_data_i[i] = b;
    step();
    t0 = cyc;
  endtask

  initial begin
    int t0, t1, dc;
    logic       prev_sclk[2];
    logic       prev_mosi[2];
    bits[0] = 8'h00; bits[1] = 8'h00; done_cnt[0] = 0; done_cnt[1] = 0;
    prev_sclk[0] = 1'b0; prev_sclk[1] = 1'b0; prev_mosi[0] = 1'b0; prev_mosi[1] = 1'b0;

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          compare_dut(i);
          if (sclk_o[i] === 1'b1 && prev_sclk[i] === 1'b0) bits[i] = {bits[i][6:0], prev_mosi[i]};
          if (done_o[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
          prev_sclk[i] = sclk_o[i];
          prev_mosi[i] = mosi_o[i];
        end
      end
    join_none

    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs_n", i, {7'd0, cs_n_o[i]}, 8'h01);
      chk("rst_sel", i, {5'd0, sel_o[i]}, 8'h07);
      chk("rst_busy", i, {7'd0, busy_o[i]}, 8'h00);
      chk("rst_tx_word", i, tx_word_o[i], 8'h00);
    end
    rst_n = 1'b1;
    repeat (2) step();

    // Single byte 8'hA5 at D=4, with tx_data disturbed after acceptance.
    dc = done_cnt[0];
    launch(0, 8'hA5, t0);
    start_i[0] = 1'b0; tx_data_i[0] = 8'h00;
    chk("t0_cs_n", 0, {7'd0, cs_n_o[0]}, 8'h00);
    goto(t0 + 3);  chk("pre_rise0", 0, {7'd0, sclk_o[0]}, 8'h00);
    goto(t0 + 4);  chk("rise0", 0, {7'd0, sclk_o[0]}, 8'h01);
    goto(t0 + 7);  chk("sel_t7", 0, {5'd0, sel_o[0]}, 8'h07);
    goto(t0 + 8);  chk("sel_t8", 0, {5'd0, sel_o[0]}, 8'h06);
                   chk("mosi_lag_t8", 0, {7'd0, mosi_o[0]}, 8'h01);
    goto(t0 + 9);  chk("mosi_t9", 0, {7'd0, mosi_o[0]}, 8'h00);
    goto(t0 + 63); chk("sel_t63", 0, {5'd0, sel_o[0]}, 8'h00);
    goto(t0 + 64); chk("sel_t64", 0, {5'd0, sel_o[0]}, 8'h07);
    goto(t0 + 67); chk("done_t67", 0, {7'd0, done_o[0]}, 8'h00);
    goto(t0 + 68); chk("done_t68", 0, {7'd0, done_o[0]}, 8'h01);
`ifdef SPI_SEQ_MISO_CAPTURE_EN
    chk("rx_at_done", 0, rx_data_o[0], 8'hFF);
`else
    chk("rx_at_done", 0, rx_data_o[0], 8'h00);
`endif
    chk("mosi_bits_a5", 0, bits[0], 8'hA5);
    goto(t0 + 71); chk("busy_t71", 0, {7'd0, busy_o[0]}, 8'h01);
    goto(t0 + 72); chk("busy_t72", 0, {7'd0, busy_o[0]}, 8'h00);
    chk("one_done_a5", 0, 8'(done_cnt[0] - dc), 8'h01);

    // Start while busy, then a held start accepted on the GAP-end edge.
    repeat (3) step();
    dc = done_cnt[0];
    launch(0, 8'h3C, t0);
    start_i[0] = 1'b0; tx_data_i[0] = 8'h00;
    goto(t0 + 9);  start_i[0] = 1'b1; tx_data_i[0] = 8'hFF;
    step();        start_i[0] = 1'b0;
    goto(t0 + 39); start_i[0] = 1'b1;
    step();        start_i[0] = 1'b0;
    goto(t0 + 69); start_i[0] = 1'b1;
    goto(t0 + 71);
    chk("bits_3c", 0, bits[0], 8'h3C);
    chk("one_done_3c", 0, 8'(done_cnt[0] - dc), 8'h01);
    goto(t0 + 72);
    start_i[0] = 1'b0;
    chk("held_accept_busy", 0, {7'd0, busy_o[0]}, 8'h01);
    chk("held_accept_word", 0, tx_word_o[0], 8'hFF);
    goto(t0 + 146);
    chk("bits_ff", 0, bits[0], 8'hFF);
    chk("two_done", 0, 8'(done_cnt[0] - dc), 8'h02);

    // Asynchronous reset in the middle of a transfer.
    repeat (2) step();
    launch(0, 8'h99, t0);
    start_i[0] = 1'b0;
    goto(t0 + 29);
    chk("sclk_before_rst", 0, {7'd0, sclk_o[0]}, 8'h01);
    dc = done_cnt[0];
    rst_n = 1'b0;
    #1;
    chk("async_cs_n", 0, {7'd0, cs_n_o[0]}, 8'h01);
    chk("async_sclk", 0, {7'd0, sclk_o[0]}, 8'h00);
    chk("async_busy", 0, {7'd0, busy_o[0]}, 8'h00);
    repeat (3) step();
    rst_n = 1'b1;
    goto(t0 + 80);
    chk("no_done_after_rst", 0, 8'(done_cnt[0] - dc), 8'h00);
    launch(0, 8'h81, t1);
    start_i[0] = 1'b0;
    goto(t1 + 72);
    chk("bits_81", 0, bits[0], 8'h81);
    chk("done_81", 0, 8'(done_cnt[0] - dc), 8'h01);

    // Minimum divider D=2 with MISO capture.
    slave_byte = 8'h5A;
    launch(1, 8'h01, t0);
    start_i[1] = 1'b0; tx_data_i[1] = 8'hEE;
    goto(t0 + 2);  chk("b_rise0", 1, {7'd0, sclk_o[1]}, 8'h01);
    goto(t0 + 33); chk("b_done_t33", 1, {7'd0, done_o[1]}, 8'h00);
    goto(t0 + 34); chk("b_done_t34", 1, {7'd0, done_o[1]}, 8'h01);
`ifdef SPI_SEQ_MISO_CAPTURE_EN
    chk("b_rx_at_done", 1, rx_data_o[1], 8'h5A);
`else
    chk("b_rx_at_done", 1, rx_data_o[1], 8'h00);
`endif
    chk("b_bits_01", 1, bits[1], 8'h01);
    goto(t0 + 35); chk("b_busy_t35", 1, {7'd0, busy_o[1]}, 8'h01);
    goto(t0 + 36); chk("b_busy_t36", 1, {7'd0, busy_o[1]}, 8'h00);

    // Start held high continuously at D=2.
    repeat (2) step();
    launch(1, 8'hC3, t0);
    tx_data_i[1] = 8'h0F;
    goto(t0 + 35); chk("b_bits_c3", 1, bits[1], 8'hC3);
    goto(t0 + 36);
    start_i[1] = 1'b0;
    chk("b_b2b_word", 1, tx_word_o[1], 8'h0F);
    chk("b_b2b_cs_n", 1, {7'd0, cs_n_o[1]}, 8'h00);
    goto(t0 + 74);
    chk("b_bits_0f", 1, bits[1], 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
